matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer.sv | 141 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// 4x4 unsigned matrix multiply sequencer: streams A and B out of a 1-cycle-latency SRAM
// into local registers, then emits one C element every 5 cycles (4 MAC + 1 EMIT).
module matmul_sequencer #(
    parameter int A_BASE = 0,
    parameter int B_BASE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        sram_en,
    output logic [10:0] sram_addr,
    input  logic [17:0] sram_rdata,
    output logic        res_valid,
    output logic [3:0]  res_idx,
    output logic [17:0] res_data
);

    typedef enum logic [2:0] {IDLE, LOAD, LOAD_WAIT, MAC, EMIT, FINISH} state_t;

    localparam logic [10:0] A_ADDR = 11'(A_BASE);
    localparam logic [10:0] B_ADDR = 11'(B_BASE);

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  i, j, k;
    logic [17:0] acc;
    logic [7:0]  a_mem [16];
    logic [7:0]  b_mem [16];

    logic [7:0]  a_op, b_op;
    logic [15:0] prod;
    logic [17:0] acc_next;
    logic [4:0]  cnt_inc;
    logic [4:0]  cap_idx;
    logic [10:0] addr_next;
    logic        unused_upper;

    // Only the low byte of each SRAM word is an element.
    assign unused_upper = ^sram_rdata[17:8];

    always_comb begin
        a_op      = a_mem[{i, k}];
        b_op      = b_mem[{k, j}];
        prod      = 16'(a_op) * 16'(b_op);
        acc_next  = ((k == 2'd0) ? 18'd0 : acc) + {2'b00, prod};
        cnt_inc   = cnt + 5'd1;
        cap_idx   = cnt - 5'd1;
        addr_next = cnt_inc[4] ? (B_ADDR + {7'd0, cnt_inc[3:0]})
                               : (A_ADDR + {7'd0, cnt_inc[3:0]});
    end

    // Read data trails its address by one cycle, so LOAD captures element cnt-1
    // and LOAD_WAIT picks up the final B element. Contents need no reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == LOAD && cnt != 5'd0) begin
                if (!cap_idx[4])
                    a_mem[cap_idx[3:0]] <= sram_rdata[7:0];
                else
                    b_mem[cap_idx[3:0]] <= sram_rdata[7:0];
            end else if (state == LOAD_WAIT) begin
                b_mem[15] <= sram_rdata[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sram_en   <= 1'b0;
            sram_addr <= 11'd0;
            res_valid <= 1'b0;
            res_idx   <= 4'd0;
            res_data  <= 18'd0;
            acc       <= 18'd0;
            cnt       <= 5'd0;
            i         <= 2'd0;
            j         <= 2'd0;
            k         <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        sram_en   <= 1'b1;
                        sram_addr <= A_ADDR;
                        cnt       <= 5'd0;
                    end
                end
                LOAD: begin
                    if (cnt == 5'd31) begin
                        state   <= LOAD_WAIT;
                        sram_en <= 1'b0;
                    end else begin
                        cnt       <= cnt_inc;
                        sram_addr <= addr_next;
                    end
                end
                LOAD_WAIT: begin
                    state <= MAC;
                    i     <= 2'd0;
                    j     <= 2'd0;
                    k     <= 2'd0;
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + 2'd1;
                    // The final term is folded straight into the result register.
                    if (k == 2'd3) begin
                        state     <= EMIT;
                        res_valid <= 1'b1;
                        res_idx   <= {i, j};
                        res_data  <= acc_next;
                    end
                end
                EMIT: begin
                    res_valid <= 1'b0;
                    if ({i, j} == 4'hF) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state  <= MAC;
                        {i, j} <= {i, j} + 4'd1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: expected strobes (index, data, cycle) are queued
// when a run is launched and retired as the DUT emits them.
module tb_matmul_sequencer;

    localparam int A_BASE = 'h100;
    localparam int B_BASE = 'h7F0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, sram_en, res_valid;
    logic [10:0] sram_addr;
    logic [17:0] sram_rdata = 18'd0;
    logic [3:0]  res_idx;
    logic [17:0] res_data;

    matmul_sequencer #(.A_BASE(A_BASE), .B_BASE(B_BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
    );

    always #5 clk = ~clk;

    logic [17:0] mem [2048];
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_en) sram_rdata <= mem[sram_addr];
    end

    typedef struct {
        int idx;
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   done_q[$];
    int   checks = 0, failures = 0;
    int   strobes = 0, dones = 0, en_cnt = 0;
    int   last_data = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int idx);
        int s = 0;
        int r = idx / 4;
        int c = idx % 4;
        for (int kk = 0; kk < 4; kk++)
            s += int'(mem[A_BASE + r*4 + kk][7:0]) * int'(mem[B_BASE + kk*4 + c][7:0]);
        return s;
    endfunction

    task automatic push_run(input int t);
        for (int n = 0; n < 16; n++)
            sb.push_back('{n, model(n), t + 38 + 5*n});
        done_q.push_back(t + 114);
    endtask

    // Call at a negedge with the DUT idle; the current cycle is the sampling cycle T.
    task automatic start_run(output int t);
        t = cyc;
        start = 1'b1;
        push_run(t);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0 || done_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("timeout_busy", busy, 0);
            chk("timeout_pending", sb.size() + done_q.size(), 0);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sram_en"}, sram_en, 0);
        chk({tag, "_sram_addr"}, sram_addr, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
        chk({tag, "_res_data"}, res_data, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (sram_en) en_cnt++;
        if (res_valid) begin
            strobes++;
            last_data = int'(res_data);
            if (sb.size() == 0) begin
                chk("strobe_unexpected", res_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("res_idx", res_idx, e.idx);
                chk("res_data", res_data, e.data);
                chk("strobe_cyc", cyc, e.cyc);
            end
        end
        if (done) begin
            dones++;
            if (done_q.size() == 0) begin
                chk("done_unexpected", done, 0);
            end else begin
                d = done_q.pop_front();
                chk("done_cyc", cyc, d);
            end
        end
    end

    initial begin
        int t, s0, d0;
        for (int a = 0; a < 2048; a++) mem[a] = 18'($urandom);

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Identity A (junk upper bits), B[n] = n+1; also walks the address sequence.
        for (int n = 0; n < 16; n++) begin
            mem[A_BASE + n] = 18'h15500 | ((n / 4 == n % 4) ? 18'd1 : 18'd0);
            mem[B_BASE + n] = 18'(n + 1);
        end
        en_cnt = 0;
        start_run(t);
        for (int c = 0; c < 32; c++) begin
            chk("sram_en_load", sram_en, 1);
            chk("sram_addr", sram_addr, (c < 16) ? (A_BASE + c) : (B_BASE + c - 16));
            @(negedge clk);
        end
        chk("sram_en_wait", sram_en, 0);
        chk("sram_addr_hold", sram_addr, B_BASE + 15);
        chk("busy_run", busy, 1);
        wait_idle();
        chk("en_cycles", en_cnt, 32);
        chk("idx_hold", res_idx, 15);
        chk("data_hold", res_data, 16);

        // All-maximum elements with upper SRAM bits set.
        for (int n = 0; n < 16; n++) begin
            mem[A_BASE + n] = 18'h3FFFF;
            mem[B_BASE + n] = 18'h3FFFF;
        end
        start_run(t);
        wait_idle();
        chk("max_last", last_data, 260100);

        // Random elements.
        for (int n = 0; n < 16; n++) begin
            mem[A_BASE + n] = 18'($urandom);
            mem[B_BASE + n] = 18'($urandom);
        end
        start_run(t);
        wait_idle();

        // Start pulse while busy is ignored.
        s0 = strobes;
        d0 = dones;
        start_run(t);
        while (cyc < t + 50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("busy_start_strobes", strobes - s0, 16);
        chk("busy_start_dones", dones - d0, 1);
        chk("busy_start_idle", busy, 0);

        // Held start: back-to-back runs with a single idle cycle.
        t = cyc;
        start = 1'b1;
        push_run(t);
        push_run(t + 115);
        while (cyc < t + 114) @(negedge clk);
        chk("held_busy_114", busy, 1);
        @(negedge clk);
        chk("held_busy_115", busy, 0);
        @(negedge clk);
        chk("held_busy_116", busy, 1);
        chk("held_en_116", sram_en, 1);
        chk("held_addr_116", sram_addr, A_BASE);
        start = 1'b0;
        wait_idle();

        // Reset mid-run: nothing further may be emitted.
        start_run(t);
        while (cyc < t + 60) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        done_q.delete();
        s0 = strobes;
        d0 = dones;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("midrst_idle", busy, 0);
        chk("midrst_strobes", strobes - s0, 0);
        chk("midrst_dones", dones - d0, 0);

        chk("sb_leftover", sb.size() + done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
